// File: rtl/cpu_pkg.sv
// Shared CPU types: store-type codes and the store-buffer entry layout.
package cpu_pkg;
  typedef enum logic [1:0] {
    ST_W    = 2'd0,
    ST_H    = 2'd1,
    ST_B    = 2'd2,
    ST_NONE = 2'd3
  } st_type_e;

  typedef struct packed {
    st_type_e    st_type;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Store/load/memory-write signals between the MEM stage, the store buffer and data memory.
interface store_buffer_if;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_stall;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        dm_ready;
  logic        dm_wr;
  logic [1:0]  dm_store_type;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic        empty;

  modport slave (
    input  st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, dm_ready,
    output st_stall, ld_stall, dm_wr, dm_store_type, dm_addr, dm_din, empty
  );

  modport master (
    output st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, dm_ready,
    input  st_stall, ld_stall, dm_wr, dm_store_type, dm_addr, dm_din, empty
  );
endinterface

// File: rtl/sb_fifo_ctrl.sv
// Circular-queue bookkeeping: head/tail pointers, occupancy, gated push/pop.
module sb_fifo_ctrl #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req_i,
  input  logic          pop_req_i,
  output logic          push_o,
  output logic          pop_o,
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Push gated on registered full only, so the pop request never reaches the push path.
  assign push_o  = push_req_i & ~full_o;
  assign pop_o   = pop_req_i & ~empty_o;

  always_comb begin
    head_d  = head_q + AW'(pop_o);
    tail_d  = tail_q + AW'(push_o);
    count_d = count_q + (AW+1)'(push_o) - (AW+1)'(pop_o);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to data memory, word-granular load hazard stall.
module store_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CMP_HI = 11
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int AW = $clog2(DEPTH);

  logic          push, pop, full, empty;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  sb_entry_t     mem_q [DEPTH];
  sb_entry_t     head_e;
  logic [DEPTH-1:0] hit;
  logic          unused_ld_bits;

  sb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .push_req_i (sb.st_valid & (st_type_e'(sb.st_type) != ST_NONE)),
    .pop_req_i  (sb.dm_ready),
    .push_o     (push),
    .pop_o      (pop),
    .head_o     (head),
    .tail_o     (tail),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_ff @(posedge clk) begin
    if (push) mem_q[tail] <= '{st_type: st_type_e'(sb.st_type), addr: sb.st_addr, data: sb.st_data};
  end

  // An entry is live when its distance from head is below count; this includes
  // the entry popping this cycle, so a matching load stays stalled until after the edge.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [AW-1:0] off;
    assign off    = AW'(i) - head;
    assign hit[i] = ({1'b0, off} < count) &&
                    (mem_q[i].addr[CMP_HI:2] == sb.ld_addr[CMP_HI:2]);
  end

  always_comb begin
    head_e = '0;
    if (!empty) head_e = mem_q[head];
  end

  assign sb.st_stall      = sb.st_valid & full;
  // A load alongside a store is illegal; stall it unconditionally.
  assign sb.ld_stall      = sb.ld_valid & (sb.st_valid | (|hit));
  assign sb.dm_wr         = pop;
  assign sb.dm_store_type = head_e.st_type;
  assign sb.dm_addr       = head_e.addr;
  assign sb.dm_din        = head_e.data;
  assign sb.empty         = empty;
  assign unused_ld_bits   = ^sb.ld_addr;
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected writes queued at acceptance, checked at dm_wr.
module tb_store_buffer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  store_buffer_if sbif ();

  store_buffer #(.DEPTH(4), .CMP_HI(11)) dut (.clk(clk), .rst(rst), .sb(sbif));

  always #5 clk = ~clk;

  sb_entry_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;

  // Memory-side monitor: every write must match the oldest outstanding store.
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst && sbif.dm_wr) begin
      n_wr++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: got addr=%h din=%h, required no write", sbif.dm_addr, sbif.dm_din);
      end else begin
        e = sbq.pop_front();
        if ({sbif.dm_store_type, sbif.dm_addr, sbif.dm_din} !== e) begin
          n_err++;
          $display("FAIL write_order: got t=%0d a=%h d=%h, required t=%0d a=%h d=%h",
                   sbif.dm_store_type, sbif.dm_addr, sbif.dm_din, e.st_type, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                             output int waited);
    waited        = 0;
    sbif.st_valid = 1'b1;
    sbif.st_type  = t;
    sbif.st_addr  = a;
    sbif.st_data  = d;
    @(negedge clk);
    while (sbif.st_stall && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (sbif.st_stall) begin
      n_cmp++; n_err++;
      $display("FAIL store_timeout: st_stall still 1 after %0d cycles, required 0", waited);
    end else if (t != 2'd3) begin
      sbq.push_back('{st_type: st_type_e'(t), addr: a, data: d});
    end
    @(posedge clk); #1;
    sbif.st_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k = 0;
    @(negedge clk);
    while (!sbif.empty && k < 50) begin
      k++;
      @(negedge clk);
    end
    n_cmp++;
    if (!sbif.empty) begin
      n_err++;
      $display("FAIL drain_timeout: empty=%0b, required 1", sbif.empty);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({sbif.empty, sbif.dm_wr, sbif.st_stall, sbif.ld_stall} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: got empty/wr/sst/lst=%b, required 1000",
               {sbif.empty, sbif.dm_wr, sbif.st_stall, sbif.ld_stall});
    end
    n_cmp++;
    if ({sbif.dm_store_type, sbif.dm_addr, sbif.dm_din} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_dm: got t=%0d a=%h d=%h, required 0", sbif.dm_store_type, sbif.dm_addr, sbif.dm_din);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sbif.empty, sbif.dm_wr} !== 2'b10) begin
      n_err++;
      $display("FAIL post_reset: got empty/wr=%b, required 10", {sbif.empty, sbif.dm_wr});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    sbif.dm_ready = 1'b1;
    sbif.st_valid = 1'b1;
    sbif.st_type  = 2'd0;
    sbif.st_addr  = 32'h10;
    sbif.st_data  = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (sbif.dm_wr !== 1'b0) begin
      n_err++;
      $display("FAIL single_early: dm_wr=%0b before acceptance, required 0", sbif.dm_wr);
    end
    sbq.push_back('{st_type: ST_W, addr: 32'h10, data: 32'hDEADBEEF});
    @(posedge clk); #1;
    sbif.st_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sbif.dm_wr, sbif.dm_store_type, sbif.dm_addr, sbif.dm_din} !== {1'b1, 2'd0, 32'h10, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL single_write: got wr=%0b t=%0d a=%h d=%h, required 1/0/10/deadbeef",
               sbif.dm_wr, sbif.dm_store_type, sbif.dm_addr, sbif.dm_din);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sbif.empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_empty: empty=%0b, required 1", sbif.empty);
    end
  endtask

  task automatic test_full();
    int w;
    sbif.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(2'd0, 32'(i * 4), 32'hA000_0000 + 32'(i), w);
      n_cmp++;
      if (w != 0) begin
        n_err++;
        $display("FAIL fill_accept%0d: waited %0d cycles, required 0", i, w);
      end
    end
    sbif.st_valid = 1'b1;
    sbif.st_type  = 2'd0;
    sbif.st_addr  = 32'h10;
    sbif.st_data  = 32'hA000_0004;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (sbif.st_stall !== 1'b1) begin
        n_err++;
        $display("FAIL full_stall: st_stall=%0b, required 1", sbif.st_stall);
      end
    end
    @(posedge clk); #1;
    sbif.dm_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sbif.st_stall !== 1'b1) begin
      n_err++;
      $display("FAIL full_pop_cycle: st_stall=%0b while popping at full, required 1", sbif.st_stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (sbif.st_stall !== 1'b0) begin
      n_err++;
      $display("FAIL full_release: st_stall=%0b after first pop, required 0", sbif.st_stall);
    end
    sbq.push_back('{st_type: ST_W, addr: 32'h10, data: 32'hA000_0004});
    @(posedge clk); #1;
    sbif.st_valid = 1'b0;
    wait_empty();
  endtask

  task automatic test_wrap();
    int w;
    int stalls = 0;
    int wr0    = n_wr;
    sbif.dm_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_store(2'd2, 32'h20 + 32'(i), 32'(8'h50 + i), w);
      stalls += w;
    end
    wait_empty();
    n_cmp++;
    if (stalls != 0) begin
      n_err++;
      $display("FAIL wrap_stall: %0d stall cycles, required 0", stalls);
    end
    n_cmp++;
    if (n_wr - wr0 != 10) begin
      n_err++;
      $display("FAIL wrap_count: %0d writes, required 10", n_wr - wr0);
    end
  endtask

  task automatic test_hazard();
    int w;
    sbif.dm_ready = 1'b0;
    drive_store(2'd1, 32'h102, 32'h0000_1234, w);
    sbif.ld_valid = 1'b1;
    sbif.ld_addr  = 32'h103;
    @(negedge clk);
    n_cmp++;
    if (sbif.ld_stall !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_same_word: ld_stall=%0b, required 1", sbif.ld_stall);
    end
    sbif.ld_addr = 32'h104;
    #1;
    n_cmp++;
    if (sbif.ld_stall !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_next_word: ld_stall=%0b, required 0", sbif.ld_stall);
    end
    sbif.ld_addr = 32'h103;
    @(posedge clk); #1;
    sbif.dm_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sbif.ld_stall !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_pop_cycle: ld_stall=%0b while entry pops, required 1", sbif.ld_stall);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (sbif.ld_stall !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_clear: ld_stall=%0b after pop, required 0", sbif.ld_stall);
    end
    sbif.ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    int w;
    sbif.dm_ready = 1'b0;
    drive_store(2'd0, 32'h40, 32'h1111_1111, w);
    drive_store(2'd0, 32'h44, 32'h2222_2222, w);
    @(negedge clk);
    n_cmp++;
    if (dut.u_ctrl.count_q !== 3'd2) begin
      n_err++;
      $display("FAIL pp_count_pre: count=%0d, required 2", dut.u_ctrl.count_q);
    end
    @(posedge clk); #1;
    sbif.dm_ready = 1'b1;
    sbif.st_valid = 1'b1;
    sbif.st_type  = 2'd0;
    sbif.st_addr  = 32'h48;
    sbif.st_data  = 32'h3333_3333;
    @(negedge clk);
    sbq.push_back('{st_type: ST_W, addr: 32'h48, data: 32'h3333_3333});
    @(posedge clk); #1;
    sbif.st_valid = 1'b0;
    sbif.dm_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.u_ctrl.count_q !== 3'd2) begin
      n_err++;
      $display("FAIL pp_count_post: count=%0d, required 2", dut.u_ctrl.count_q);
    end
    sbif.st_valid = 1'b1;
    sbif.st_type  = 2'd3;
    sbif.st_addr  = 32'h4C;
    #1;
    n_cmp++;
    if (sbif.st_stall !== 1'b0) begin
      n_err++;
      $display("FAIL reserved_stall: st_stall=%0b, required 0", sbif.st_stall);
    end
    @(posedge clk); #1;
    sbif.st_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.u_ctrl.count_q !== 3'd2) begin
      n_err++;
      $display("FAIL reserved_count: count=%0d, required 2", dut.u_ctrl.count_q);
    end
    @(posedge clk); #1;
    sbif.dm_ready = 1'b1;
    wait_empty();
  endtask

  task automatic test_reset_mid();
    int w;
    int wr0;
    sbif.dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_store(2'd0, 32'h80 + 32'(i * 4), 32'hC0 + 32'(i), w);
    @(negedge clk);
    n_cmp++;
    if (sbif.empty !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pending: empty=%0b, required 0", sbif.empty);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({sbif.empty, sbif.dm_addr} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL mid_async: empty=%0b dm_addr=%h, required 1/0", sbif.empty, sbif.dm_addr);
    end
    sbq.delete();
    wr0 = n_wr;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    sbif.dm_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_wr != wr0 || sbif.empty !== 1'b1) begin
      n_err++;
      $display("FAIL mid_no_write: writes=%0d empty=%0b, required 0/1", n_wr - wr0, sbif.empty);
    end
  endtask

  initial begin
    sbif.st_valid = 1'b0;
    sbif.st_type  = 2'd0;
    sbif.st_addr  = '0;
    sbif.st_data  = '0;
    sbif.ld_valid = 1'b0;
    sbif.ld_addr  = '0;
    sbif.dm_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_hazard();
    test_push_pop();
    test_reset_mid();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d stores never written, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
